// File: rtl/nau_pkg.sv
// Shared definitions for the next-address unit: op encodings, condition codes,
// flag bit positions and the branch-condition evaluator.
package nau_pkg;

  typedef enum logic [2:0] {
    NAU_SEQ  = 3'd0,
    NAU_BR   = 3'd1,
    NAU_JMP  = 3'd2,
    NAU_CALL = 3'd3,
    NAU_RET  = 3'd4
  } nau_op_e;

  localparam logic [3:0] CC_AL = 4'd0;
  localparam logic [3:0] CC_EQ = 4'd1;
  localparam logic [3:0] CC_NE = 4'd2;
  localparam logic [3:0] CC_CS = 4'd3;
  localparam logic [3:0] CC_CC = 4'd4;
  localparam logic [3:0] CC_MI = 4'd5;
  localparam logic [3:0] CC_PL = 4'd6;
  localparam logic [3:0] CC_VS = 4'd7;
  localparam logic [3:0] CC_VC = 4'd8;
  localparam logic [3:0] CC_LT = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_GT = 4'd11;
  localparam logic [3:0] CC_LE = 4'd12;
  localparam logic [3:0] CC_HI = 4'd13;
  localparam logic [3:0] CC_LS = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  // Signed compares use S^V (true "less than"); unsigned use C and Z.
  function automatic logic nau_eval_cond(input logic [3:0] cc, input logic [3:0] f);
    logic z, c, s, v, lt;
    z  = f[FLAG_Z];
    c  = f[FLAG_C];
    s  = f[FLAG_S];
    v  = f[FLAG_V];
    lt = s ^ v;
    case (cc)
      CC_AL:   return 1'b1;
      CC_EQ:   return z;
      CC_NE:   return !z;
      CC_CS:   return c;
      CC_CC:   return !c;
      CC_MI:   return s;
      CC_PL:   return !s;
      CC_VS:   return v;
      CC_VC:   return !v;
      CC_LT:   return lt;
      CC_GE:   return !lt;
      CC_GT:   return !z && !lt;
      CC_LE:   return z || lt;
      CC_HI:   return c && !z;
      CC_LS:   return !c || z;
      CC_NV:   return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a write pointer plus a saturating count, so a
// push into a full stack silently replaces the oldest entry.
module return_addr_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == CNT_W'(0));
  assign dout  = mem_q[wr_ptr_q - PTR_W'(1)];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf      = push && full;
    unf      = pop && empty;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (!full) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end else if (pop && !empty) begin
      wr_ptr_d = wr_ptr_q - PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; the count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/next_address_unit.sv
// Program-counter sequencer: flag register, condition evaluation, branch/jump/
// call/return target selection and the return-address stack.
module next_address_unit
  import nau_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              OFFSET_W  = 16,
  parameter int              RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flag_we,
  input  logic                z_in,
  input  logic                c_in,
  input  logic                s_in,
  input  logic                v_in,
  input  logic [2:0]          op,
  input  logic [3:0]          br_cond,
  input  logic [OFFSET_W-1:0] br_offset,
  input  logic [ADDR_W-1:0]   jmp_target,
  output logic [ADDR_W-1:0]   pc,
  output logic                br_taken,
  output logic [3:0]          flags,
  output logic                ras_full,
  output logic                ras_empty,
  output logic                ras_err
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              br_taken_q, br_taken_d;
  logic [3:0]        flags_q, flags_d;
  logic              ras_err_q, ras_err_d;

  logic [3:0]        eff_flags;
  logic [ADDR_W-1:0] pc_inc, off_sext, ras_dout;
  logic              cond_ok, ras_push, ras_pop, ras_ovf, ras_unf;

  return_addr_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_inc),
    .dout  (ras_dout),
    .full  (ras_full),
    .empty (ras_empty),
    .ovf   (ras_ovf),
    .unf   (ras_unf)
  );

  // Incoming flags bypass the register so a compare and branch can share a cycle.
  always_comb begin
    eff_flags = flag_we ? {z_in, c_in, s_in, v_in} : flags_q;
    flags_d   = eff_flags;
    pc_inc    = pc_q + ADDR_W'(1);
    off_sext  = ADDR_W'($signed(br_offset));
    cond_ok   = nau_eval_cond(br_cond, eff_flags);
  end

  always_comb begin
    pc_d       = pc_q;
    br_taken_d = 1'b0;
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    if (!stall) begin
      case (nau_op_e'(op))
        NAU_BR: begin
          if (cond_ok) begin
            pc_d       = pc_inc + off_sext;
            br_taken_d = 1'b1;
          end else begin
            pc_d = pc_inc;
          end
        end
        NAU_JMP: begin
          pc_d       = jmp_target;
          br_taken_d = 1'b1;
        end
        NAU_CALL: begin
          ras_push   = 1'b1;
          pc_d       = jmp_target;
          br_taken_d = 1'b1;
        end
        NAU_RET: begin
          ras_pop = 1'b1;
          if (ras_empty) begin
            pc_d = pc_inc;
          end else begin
            pc_d       = ras_dout;
            br_taken_d = 1'b1;
          end
        end
        default: pc_d = pc_inc;
      endcase
    end else begin
      pc_d = pc_q;
    end
    ras_err_d = ras_err_q || ras_ovf || ras_unf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      br_taken_q <= 1'b0;
      flags_q    <= 4'd0;
      ras_err_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      br_taken_q <= br_taken_d;
      flags_q    <= flags_d;
      ras_err_q  <= ras_err_d;
    end
  end

  assign pc       = pc_q;
  assign br_taken = br_taken_q;
  assign flags    = flags_q;
  assign ras_err  = ras_err_q;

endmodule

// File: tb/tb_next_address_unit.sv
// Self-checking bench for next_address_unit: expected PC/br_taken pairs are
// queued as stimulus is driven and compared one cycle later.
module tb_next_address_unit;
  import nau_pkg::*;

  localparam int          AW    = 32;
  localparam int          OW    = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h100;

  logic          clk, rst, stall, flag_we, z_in, c_in, s_in, v_in;
  logic [2:0]    op;
  logic [3:0]    br_cond;
  logic [OW-1:0] br_offset;
  logic [AW-1:0] jmp_target;
  logic [AW-1:0] pc;
  logic          br_taken, ras_full, ras_empty, ras_err;
  logic [3:0]    flags;

  next_address_unit #(
    .ADDR_W(AW), .OFFSET_W(OW), .RAS_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flag_we(flag_we),
    .z_in(z_in), .c_in(c_in), .s_in(s_in), .v_in(v_in),
    .op(op), .br_cond(br_cond), .br_offset(br_offset), .jmp_target(jmp_target),
    .pc(pc), .br_taken(br_taken), .flags(flags),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { string name; logic [31:0] pc; logic bt; } exp_t;
  typedef struct {
    logic [2:0] op; logic [3:0] cc; logic [15:0] off; logic [31:0] tgt;
    logic fwe; logic [3:0] f; logic tk;
  } step_t;

  exp_t        sb[$];
  exp_t        e;
  step_t       steps[$];
  logic [31:0] stk[$];
  logic [31:0] model_pc;
  int          tests_run = 0;
  int          tests_failed = 0;

  task automatic drive(input logic [2:0] o, input logic [3:0] cc, input logic [15:0] off,
                       input logic [31:0] tgt, input logic fwe, input logic [3:0] f);
    op = o; br_cond = cc; br_offset = off; jmp_target = tgt;
    flag_we = fwe; {z_in, c_in, s_in, v_in} = f;
  endtask

  task automatic expect_pc(input string n, input logic [31:0] p, input logic b);
    exp_t x;
    x.name = n; x.pc = p; x.bt = b;
    sb.push_back(x);
  endtask

  task automatic add_step(input logic [2:0] o, input logic [3:0] cc, input logic [15:0] off,
                          input logic [31:0] tgt, input logic fwe, input logic [3:0] f,
                          input logic tk);
    step_t s;
    s.op = o; s.cc = cc; s.off = off; s.tgt = tgt; s.fwe = fwe; s.f = f; s.tk = tk;
    steps.push_back(s);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0;
    drive(NAU_SEQ, 4'd0, 16'd0, 32'd0, 1'b0, 4'd0);
    expect_pc("reset", RPC, 1'b0);
    tick();
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || br_taken !== e.bt) begin
      tests_failed++;
      $display("FAIL %s: pc=%h br_taken=%b, expected pc=%h br_taken=%b", e.name, pc, br_taken, e.pc, e.bt);
    end
    tests_run++;
    if ({flags, ras_empty, ras_full, ras_err} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_status: flags=%b empty=%b full=%b err=%b, expected 0000 1 0 0", flags, ras_empty, ras_full, ras_err);
    end
    rst = 1'b0;
    model_pc = RPC;
  endtask

  task automatic test_seq;
    for (int i = 0; i < 3; i++) begin
      drive(NAU_SEQ, 4'd0, 16'd0, 32'd0, 1'b0, 4'd0);
      expect_pc($sformatf("seq %0d", i), model_pc + 32'd1, 1'b0);
      tick();
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc || br_taken !== e.bt) begin
        tests_failed++;
        $display("FAIL %s: pc=%h br_taken=%b, expected pc=%h br_taken=%b", e.name, pc, br_taken, e.pc, e.bt);
      end
      model_pc = model_pc + 32'd1;
    end
  endtask

  task automatic test_branch_cond_wrap;
    logic [31:0] p;
    logic        b;
    add_step(NAU_JMP, 4'd0,  16'd0,   32'h200,      1'b0, 4'b0000, 1'b1);
    add_step(NAU_BR,  CC_EQ, 16'hFFFC, 32'd0,       1'b1, 4'b1000, 1'b1);
    add_step(NAU_JMP, 4'd0,  16'd0,   32'h200,      1'b0, 4'b0000, 1'b1);
    add_step(NAU_BR,  CC_NE, 16'hFFFC, 32'd0,       1'b1, 4'b1000, 1'b0);
    add_step(NAU_BR,  CC_LT, 16'd5,   32'd0,        1'b1, 4'b0010, 1'b1);
    add_step(NAU_BR,  CC_LT, 16'd5,   32'd0,        1'b1, 4'b0011, 1'b0);
    add_step(NAU_BR,  CC_HI, 16'd2,   32'd0,        1'b1, 4'b0100, 1'b1);
    add_step(NAU_BR,  CC_LS, 16'd2,   32'd0,        1'b0, 4'b0000, 1'b0);
    add_step(NAU_BR,  CC_GT, 16'd3,   32'd0,        1'b1, 4'b0000, 1'b1);
    add_step(NAU_BR,  CC_LE, 16'd3,   32'd0,        1'b1, 4'b0000, 1'b0);
    add_step(NAU_BR,  CC_NV, 16'd3,   32'd0,        1'b0, 4'b0000, 1'b0);
    add_step(NAU_BR,  CC_AL, 16'd0,   32'd0,        1'b0, 4'b0000, 1'b1);
    add_step(3'd5,    CC_AL, 16'd7,   32'h777,      1'b0, 4'b0000, 1'b0);
    add_step(NAU_JMP, 4'd0,  16'd0,   32'hFFFFFFFF, 1'b0, 4'b0000, 1'b1);
    add_step(NAU_SEQ, 4'd0,  16'd0,   32'd0,        1'b0, 4'b0000, 1'b0);
    add_step(NAU_BR,  CC_AL, 16'hFFFD, 32'd0,       1'b0, 4'b0000, 1'b1);
    foreach (steps[i]) begin
      drive(steps[i].op, steps[i].cc, steps[i].off, steps[i].tgt, steps[i].fwe, steps[i].f);
      if (steps[i].op == NAU_JMP) begin
        p = steps[i].tgt; b = 1'b1;
      end else if (steps[i].op == NAU_BR && steps[i].tk) begin
        p = model_pc + 32'd1 + {{16{steps[i].off[15]}}, steps[i].off}; b = 1'b1;
      end else begin
        p = model_pc + 32'd1; b = 1'b0;
      end
      expect_pc($sformatf("branch step %0d", i), p, b);
      tick();
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc || br_taken !== e.bt) begin
        tests_failed++;
        $display("FAIL %s: pc=%h br_taken=%b, expected pc=%h br_taken=%b", e.name, pc, br_taken, e.pc, e.bt);
      end
      model_pc = p;
    end
  endtask

  task automatic test_ras;
    logic [31:0] p;
    logic        b;
    drive(NAU_JMP, 4'd0, 16'd0, 32'h10, 1'b0, 4'd0);
    model_pc = 32'h10;
    tick();
    for (int i = 1; i <= 9; i++) begin
      drive(NAU_CALL, 4'd0, 16'd0, 32'h40 + 32'(i), 1'b0, 4'd0);
      if (stk.size() == DEPTH) void'(stk.pop_front());
      stk.push_back(model_pc + 32'd1);
      expect_pc($sformatf("call %0d", i), 32'h40 + 32'(i), 1'b1);
      tick();
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc || br_taken !== e.bt) begin
        tests_failed++;
        $display("FAIL %s: pc=%h br_taken=%b, expected pc=%h br_taken=%b", e.name, pc, br_taken, e.pc, e.bt);
      end
      model_pc = 32'h40 + 32'(i);
      if (i >= 8) begin
        tests_run++;
        if (ras_full !== 1'b1 || ras_err !== (i == 9)) begin
          tests_failed++;
          $display("FAIL ras_status call %0d: full=%b err=%b, expected full=1 err=%b", i, ras_full, ras_err, (i == 9));
        end
      end
    end
    for (int j = 0; j < 9; j++) begin
      drive(NAU_RET, 4'd0, 16'd0, 32'd0, 1'b0, 4'd0);
      if (stk.size() > 0) begin
        p = stk.pop_back(); b = 1'b1;
      end else begin
        p = model_pc + 32'd1; b = 1'b0;
      end
      expect_pc($sformatf("ret %0d", j), p, b);
      tick();
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc || br_taken !== e.bt) begin
        tests_failed++;
        $display("FAIL %s: pc=%h br_taken=%b, expected pc=%h br_taken=%b", e.name, pc, br_taken, e.pc, e.bt);
      end
      model_pc = p;
    end
    tests_run++;
    if (ras_empty !== 1'b1 || ras_full !== 1'b0 || ras_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL ras_drained: empty=%b full=%b err=%b, expected 1 0 1", ras_empty, ras_full, ras_err);
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    drive(NAU_JMP, 4'd0, 16'd0, 32'h300, 1'b1, 4'b1010);
    expect_pc("stall hold", model_pc, 1'b0);
    tick();
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || br_taken !== e.bt) begin
      tests_failed++;
      $display("FAIL %s: pc=%h br_taken=%b, expected pc=%h br_taken=%b", e.name, pc, br_taken, e.pc, e.bt);
    end
    tests_run++;
    if (flags !== 4'b1010 || ras_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_flags: flags=%b err=%b, expected 1010 1", flags, ras_err);
    end
    stall = 1'b0;
    drive(NAU_JMP, 4'd0, 16'd0, 32'h300, 1'b0, 4'd0);
    expect_pc("jmp after stall", 32'h300, 1'b1);
    tick();
    drive(NAU_SEQ, 4'd0, 16'd0, 32'd0, 1'b0, 4'd0);
    expect_pc("seq after jmp", 32'h301, 1'b0);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) tick();
      e = sb.pop_front(); tests_run++;
      if (pc !== e.pc || br_taken !== e.bt) begin
        tests_failed++;
        $display("FAIL %s: pc=%h br_taken=%b, expected pc=%h br_taken=%b", e.name, pc, br_taken, e.pc, e.bt);
      end
    end
    model_pc = 32'h301;
  endtask

  task automatic test_reset_mid;
    drive(NAU_CALL, 4'd0, 16'd0, 32'h500, 1'b0, 4'd0);
    tick();
    tests_run++;
    if (pc !== 32'h500 || ras_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL call_500: pc=%h empty=%b, expected 00000500 0", pc, ras_empty);
    end
    drive(NAU_CALL, 4'd0, 16'd0, 32'h600, 1'b1, 4'b1111);
    #3 rst = 1'b1;
    #1;
    tests_run++;
    if ({pc, br_taken, flags, ras_empty, ras_full, ras_err} !== {RPC, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: pc=%h bt=%b flags=%b empty=%b full=%b err=%b, expected %h 0 0000 1 0 0",
               pc, br_taken, flags, ras_empty, ras_full, ras_err, RPC);
    end
    tick();
    rst = 1'b0;
    drive(NAU_RET, 4'd0, 16'd0, 32'd0, 1'b0, 4'd0);
    expect_pc("ret after reset", RPC + 32'd1, 1'b0);
    tick();
    e = sb.pop_front(); tests_run++;
    if (pc !== e.pc || br_taken !== e.bt || ras_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: pc=%h br_taken=%b err=%b, expected pc=%h br_taken=%b err=1", e.name, pc, br_taken, ras_err, e.pc, e.bt);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    drive(NAU_SEQ, 4'd0, 16'd0, 32'd0, 1'b0, 4'd0);
    test_reset();
    test_seq();
    test_branch_cond_wrap();
    test_ras();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/next_address_unit.md
Name: next_address_unit

Overview:
- Generalised successor to the branch-condition logic; produces the program counter every cycle.
- Holds a 4-bit condition-flag register (Z, C, S, V) and evaluates 16 condition codes, including signed and unsigned compares.
- Selects sequential, PC-relative branch, absolute jump, call or return as the next address.
- Contains a parametrised return-address stack (RAS); sits between decode/ALU and instruction fetch.

Parameters:
- ADDR_W, 32, PC width in words.
- OFFSET_W, 16, signed branch-offset width, with OFFSET_W <= ADDR_W.
- RAS_DEPTH, 8, return-address stack entries, a power of 2 and >= 2.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC, RAS and op processing.
- flag_we  in  1  load z_in/c_in/s_in/v_in into the flag register.
- z_in, c_in, s_in, v_in  in  1 each  new flag values.
- op  in  3  next-address operation: 0 SEQ, 1 BR, 2 JMP, 3 CALL, 4 RET, 5-7 treated as SEQ.
- br_cond  in  4  condition code, used when op=BR.
- br_offset  in  OFFSET_W  signed word offset for BR.
- jmp_target  in  ADDR_W  absolute target for JMP and CALL.
- pc  out  ADDR_W  current PC (registered).
- br_taken  out  1  one-cycle pulse: the previous cycle redirected the PC.
- flags  out  4  registered {Z,C,S,V}.
- ras_full  out  1  RAS count equals RAS_DEPTH.
- ras_empty  out  1  RAS count equals 0.
- ras_err  out  1  sticky: RAS overflow or underflow occurred.

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, flags=0, br_taken=0, RAS count=0, ras_empty=1, ras_full=0, ras_err=0, RAS pointer=0.
- Effective flags: if flag_we=1, use the inputs; else use the flag register. This gives same-cycle bypass, so a compare followed by a branch in the same cycle sees the new flags.
- flags register updates on every clk edge where flag_we=1, regardless of stall.
- Condition codes, evaluated on effective flags:
  - 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 S, 6 !S, 7 V, 8 !V.
  - 9 LT = S^V, 10 GE = !(S^V), 11 GT = !Z & !(S^V), 12 LE = Z | (S^V).
  - 13 HI = C & !Z, 14 LS = !C | Z, 15 never.
- Next PC, all arithmetic modulo 2^ADDR_W:
  - SEQ: pc+1.
  - BR: taken gives pc+1+sext(br_offset); not taken gives pc+1.
  - JMP: jmp_target.
  - CALL: push pc+1; PC becomes jmp_target.
  - RET: pop; PC becomes the popped value.
- Latency: op is sampled at edge N; pc holds the new value after edge N. br_taken=1 for exactly the cycle after any redirect (taken BR, JMP, CALL, RET with non-empty RAS), otherwise 0.
- stall=1: pc, RAS and ras_err hold; br_taken<=0; op is ignored; flag_we is still honoured.
- RAS is a circular buffer: write pointer plus a count saturating at RAS_DEPTH.
  - CALL when full: overwrite the oldest entry, count stays at RAS_DEPTH, ras_err<=1.
  - RET when empty: pc<=pc+1, no redirect, br_taken<=0, count stays 0, ras_err<=1.
  - ras_err clears only on reset.
- Wrap: pc=2^ADDR_W-1 with SEQ gives 0. A negative offset below 0 wraps high.
- Reset asserted mid-operation: all state returns to reset values immediately, with no partial RAS push.

Decomposition:
- Package nau_pkg:
  - op encodings (NAU_SEQ, NAU_BR, NAU_JMP, NAU_CALL, NAU_RET).
  - 16 condition-code constants.
  - Flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_S=1, FLAG_V=0).
- Sub-module return_addr_stack:
  - Parametrised by ADDR_W and RAS_DEPTH.
  - push/pop/din/dout/full/empty/ovf/unf.
- The condition evaluator is a function in nau_pkg.

Test Plan:
- Reset with RESET_PC=0x100, then 3 cycles of SEQ -> pc 0x100, 0x101, 0x102, 0x103; br_taken stays 0.
- pc=0x200, flag_we=1 with Z=1, same cycle op=BR cond=1 offset=-4 -> pc=0x1FD next cycle; br_taken=1 for one cycle. Repeat with cond=2 -> pc=0x201.
- Signed compare: flags S=1 V=0 with cond=9 -> taken; S=1 V=1 with cond=9 -> not taken. Unsigned: C=1 Z=0 with cond=13 -> taken; cond=14 -> not taken.
- RAS_DEPTH=8: 9 CALLs from pc=0x10, each jumping to 0x40+i:
  - ras_full=1 after the 8th CALL; ras_err=1 after the 9th.
  - 8 RETs return in LIFO order, the first to 0x49 (pushed by the 9th CALL at pc=0x48).
  - The 9th RET gives pc+1 with br_taken=0.
- stall=1 during a JMP to 0x300 -> pc unchanged and br_taken=0. flag_we during the stall still updates flags=4'b1010. After stall drops, JMP to 0x300 executes.
- CALL to 0x500, then rst asserted asynchronously mid-cycle -> pc=RESET_PC immediately, ras_empty=1, ras_err=0, flags=0.
